store_bin: RTL

//  Write-back counterpart of the bin loader: after the SAT engine finishes a bin, reads the bin's

---
 rtl/store_bin_pkg.sv | 39 +++
 rtl/store_bin_select_from_n_datas.sv | 14 +
 rtl/store_bin.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/store_bin_pkg.sv
// Shared definitions for the bin write-back path: bin geometry, FSM encoding,
// lvl-state field layout and the bin base-address helper.
package store_bin_pkg;

  localparam int NUM_CLAUSES_A_BIN     = 8;
  localparam int NUM_VARS_A_BIN        = 8;
  localparam int NUM_LVLS_A_BIN        = 8;
  localparam int WIDTH_CLAUSES         = NUM_VARS_A_BIN * 2;
  localparam int WIDTH_VAR             = 12;
  localparam int WIDTH_LVL             = 16;
  localparam int WIDTH_BIN_ID          = 10;
  localparam int WIDTH_VAR_STATES      = 19;
  localparam int WIDTH_LVL_STATES      = 11;
  localparam int ADDR_WIDTH_CLAUSES    = 9;
  localparam int ADDR_WIDTH_VAR        = 9;
  localparam int ADDR_WIDTH_VAR_STATES = 9;
  localparam int ADDR_WIDTH_LVL_STATES = 9;

  localparam int CNT_W      = 6;
  localparam int SLOT_W     = $clog2(NUM_CLAUSES_A_BIN);
  localparam int LVL_SLOT_W = $clog2(NUM_LVLS_A_BIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH_LVL_STATES-2:0] dcd_bin;
    logic                        has_bkt;
  } lvl_state_t;

  // Bins are 1-based; bin b occupies words (b-1)*n+1 .. b*n of each bin RAM.
  function automatic int bin_base(input logic [WIDTH_BIN_ID-1:0] bin, input int n);
    return (int'(bin) - 1) * n + 1;
  endfunction

endpackage

// File: rtl/store_bin_select_from_n_datas.sv
// Slot-index mux over a packed bus of N equal-width words, slot 0 at the LSB.
module select_from_n_datas #(
  parameter  int WIDTH = 8,
  parameter  int N     = 8,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [WIDTH*N-1:0] datas,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   data
);

  assign data = datas[sel*WIDTH +: WIDTH];

endmodule

// File: rtl/store_bin.sv
// Writes one finished bin (clauses, var states, lvl states) from the SAT engine
// back into the bin BRAMs, one slot per cycle.
module store_bin
  import store_bin_pkg::*;
(
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start_update,
  input  logic [WIDTH_BIN_ID-1:0]                     request_bin_num_i,
  input  logic [WIDTH_LVL-1:0]                        base_lvl_i,
  input  logic [WIDTH_LVL-1:0]                        cur_lvl_i,
  output logic                                        apply_update_o,
  output logic                                        done_update,
  output logic [NUM_CLAUSES_A_BIN-1:0]                rd_carray_o,
  input  logic [WIDTH_CLAUSES-1:0]                    clause_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]  var_states_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]  lvl_states_i,
  output logic                                        ram_we_c_o,
  output logic [ADDR_WIDTH_CLAUSES-1:0]               ram_addr_c_o,
  output logic [WIDTH_CLAUSES-1:0]                    ram_data_c_o,
  output logic [ADDR_WIDTH_VAR-1:0]                   ram_addr_v_o,
  input  logic [WIDTH_VAR-1:0]                        ram_data_v_i,
  output logic                                        ram_we_vs_o,
  output logic [ADDR_WIDTH_VAR_STATES-1:0]            ram_addr_vs_o,
  output logic [WIDTH_VAR_STATES-1:0]                 ram_data_vs_o,
  output logic                                        ram_we_ls_o,
  output logic [ADDR_WIDTH_LVL_STATES-1:0]            ram_addr_ls_o,
  output logic [WIDTH_LVL_STATES-1:0]                 ram_data_ls_o
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_CLAUSES_A_BIN + 2);
  localparam logic [CNT_W-1:0] CNT_NCL   = CNT_W'(NUM_CLAUSES_A_BIN);
  localparam logic [CNT_W-1:0] CNT_NLVL  = CNT_W'(NUM_LVLS_A_BIN);

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic [WIDTH_LVL-1:0]            base_lvl_q;
  logic [WIDTH_LVL-1:0]            cur_lvl_q;
  logic [ADDR_WIDTH_CLAUSES-1:0]   base_q;
  logic                            v_vld_d1, v_vld_d2;
  logic [SLOT_W-1:0]               v_slot_d1, v_slot_d2;

  logic                            clause_phase;
  logic                            lvl_phase;
  logic [SLOT_W-1:0]               slot;
  logic [ADDR_WIDTH_CLAUSES-1:0]   slot_addr;
  logic [WIDTH_LVL-1:0]            lvl;
  logic [WIDTH_VAR_STATES-1:0]     vs_sel;
  lvl_state_t                      ls_sel;

  assign clause_phase = (state == S_STORE) && (cnt < CNT_NCL);
  assign lvl_phase    = (state == S_STORE) && (cnt < CNT_NLVL);
  assign slot         = cnt[SLOT_W-1:0];
  assign slot_addr    = base_q + ADDR_WIDTH_CLAUSES'(slot);
  assign lvl          = base_lvl_q + WIDTH_LVL'(1) + WIDTH_LVL'(cnt);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_carray_o = '0;
    if (clause_phase) rd_carray_o[slot] = 1'b1;
  end

  // The var-state slot lags two cycles: one for the var RAM address register, one for the RAM read.
  select_from_n_datas #(
    .WIDTH (WIDTH_VAR_STATES),
    .N     (NUM_VARS_A_BIN)
  ) u_sel_vs (
    .datas (var_states_i),
    .sel   (v_slot_d2),
    .data  (vs_sel)
  );

  select_from_n_datas #(
    .WIDTH (WIDTH_LVL_STATES),
    .N     (NUM_LVLS_A_BIN)
  ) u_sel_ls (
    .datas (lvl_states_i),
    .sel   (slot[LVL_SLOT_W-1:0]),
    .data  (ls_sel)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      base_lvl_q     <= '0;
      cur_lvl_q      <= '0;
      base_q         <= '0;
      v_vld_d1       <= 1'b0;
      v_vld_d2       <= 1'b0;
      v_slot_d1      <= '0;
      v_slot_d2      <= '0;
      apply_update_o <= 1'b0;
      done_update    <= 1'b0;
      ram_we_c_o     <= 1'b0;
      ram_addr_c_o   <= '0;
      ram_data_c_o   <= '0;
      ram_addr_v_o   <= '0;
      ram_we_vs_o    <= 1'b0;
      ram_addr_vs_o  <= '0;
      ram_data_vs_o  <= '0;
      ram_we_ls_o    <= 1'b0;
      ram_addr_ls_o  <= '0;
      ram_data_ls_o  <= '0;
    end else begin
      apply_update_o <= (state != S_IDLE);
      done_update    <= (state == S_DONE);
      v_vld_d1       <= clause_phase;
      v_slot_d1      <= slot;
      v_vld_d2       <= v_vld_d1;
      v_slot_d2      <= v_slot_d1;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start_update) begin
            base_lvl_q <= base_lvl_i;
            cur_lvl_q  <= cur_lvl_i;
            base_q     <= ADDR_WIDTH_CLAUSES'(bin_base(request_bin_num_i, NUM_CLAUSES_A_BIN));
            state      <= (request_bin_num_i == '0) ? S_DONE : S_STORE;
          end
        end
        S_STORE: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase

      ram_we_c_o   <= clause_phase;
      ram_addr_c_o <= clause_phase ? slot_addr : '0;
      ram_data_c_o <= clause_phase ? clause_i : '0;
      ram_addr_v_o <= clause_phase ? ADDR_WIDTH_VAR'(slot_addr) : '0;

      // Var id 0 marks an empty slot in the var RAM.
      ram_we_vs_o   <= v_vld_d2 && (ram_data_v_i != '0);
      ram_addr_vs_o <= v_vld_d2 ? ram_data_v_i[ADDR_WIDTH_VAR_STATES-1:0] : '0;
      ram_data_vs_o <= v_vld_d2 ? vs_sel : '0;

      // Levels past cur_lvl hold stale state from an abandoned branch, so they are cleared.
      ram_we_ls_o   <= lvl_phase;
      ram_addr_ls_o <= lvl_phase ? lvl[ADDR_WIDTH_LVL_STATES-1:0] : '0;
      ram_data_ls_o <= (lvl_phase && (lvl <= cur_lvl_q)) ? ls_sel : '0;
    end
  end

endmodule
